// File: rtl/data_compare4_pkg.sv
// data_compare4_pkg: shared types and constants for the data_compare4 comparator slice.
//   cmp_t          3-bit comparison result, one-hot {GT, EQ, LT}
//   CMP_GT/EQ/LT   legal one-hot result codes
//   cmp_normalize  maps any 3-bit cascade code onto a legal one-hot code
package data_compare4_pkg;

  typedef logic [2:0] cmp_t;

  localparam cmp_t CMP_GT = 3'b100;
  localparam cmp_t CMP_EQ = 3'b010;
  localparam cmp_t CMP_LT = 3'b001;

  // GT wins over LT; anything with neither bit set (010 or 000) becomes EQ.
  function automatic cmp_t cmp_normalize(input cmp_t code);
    if (code[2]) begin
      return CMP_GT;
    end else if (code[0]) begin
      return CMP_LT;
    end
    return CMP_EQ;
  endfunction

endpackage

// File: rtl/data_compare4_core.sv
// data_compare4_core: combinational magnitude compare with cascade input.
// Build option: DATA_COMPARE4_SIGNED_EN selects two's-complement comparison;
// unsigned when undefined.
// Ports:
//   data_a_i   operand A
//   data_b_i   operand B
//   cascade_i  result from the less-significant stage, {GT, EQ, LT}
//   result_o   one-hot result; ties defer to the normalized cascade input
module data_compare4_core
  import data_compare4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  cmp_t             cascade_i,
  output cmp_t             result_o
);

  logic a_gt_b;
  logic a_lt_b;

`ifdef DATA_COMPARE4_SIGNED_EN
  assign a_gt_b = $signed(data_a_i) > $signed(data_b_i);
  assign a_lt_b = $signed(data_a_i) < $signed(data_b_i);
`else
  assign a_gt_b = data_a_i > data_b_i;
  assign a_lt_b = data_a_i < data_b_i;
`endif

  always_comb begin
    result_o = cmp_normalize(cascade_i);
    if (a_gt_b) begin
      result_o = CMP_GT;
    end else if (a_lt_b) begin
      result_o = CMP_LT;
    end
  end

endmodule

// File: rtl/data_compare4.sv
// data_compare4: registered one-stage comparator with cascade input.
// Build option: DATA_COMPARE4_SIGNED_EN (signed operands when defined).
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (oData=010, oValid=0)
//   iData_a  operand A
//   iData_b  operand B
//   iData    cascade input {GT, EQ, LT}
//   iValid   inputs valid this cycle
//   oData    registered one-hot result {GT, EQ, LT}
//   oValid   oData was loaded on the last edge
module data_compare4
  import data_compare4_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  input  logic             iValid,
  output logic [2:0]       oData,
  output logic             oValid
);

  cmp_t result;
  cmp_t data_d, data_q;
  logic valid_d, valid_q;

  data_compare4_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .data_a_i (iData_a),
    .data_b_i (iData_b),
    .cascade_i(iData),
    .result_o (result)
  );

  always_comb begin
    data_d  = data_q;
    valid_d = iValid;
    if (iValid) begin
      data_d = result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= CMP_EQ;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_data_compare4.sv
module tb_data_compare4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] iData_a, iData_b;
  logic [2:0]   iData;
  logic         iValid;
  logic [2:0]   oData;
  logic         oValid;

  int checks   = 0;
  int failures = 0;

  logic [2:0] sb_q[$];
  logic [2:0] last_exp;

  data_compare4 #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iData_a(iData_a),
    .iData_b(iData_b),
    .iData  (iData),
    .iValid (iValid),
    .oData  (oData),
    .oValid (oValid)
  );

  always #5 clk = ~clk;

  // Reference: turn operands into integers, compare, defer ties to the cascade code.
  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] c);
    int va;
    int vb;
    va = int'(a);
    vb = int'(b);
`ifdef DATA_COMPARE4_SIGNED_EN
    if (a[W-1]) va = va - (1 << W);
    if (b[W-1]) vb = vb - (1 << W);
`endif
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    if (c[2]) return 3'b100;
    if (c[0]) return 3'b001;
    return 3'b010;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                       input logic v);
    logic [2:0] e;
    @(negedge clk);
    iData_a = a;
    iData_b = b;
    iData   = c;
    iValid  = v;
    if (v) begin
      e = model(a, b, c);
      sb_q.push_back(e);
      last_exp = e;
    end
  endtask

  // Monitor: pops one expected result for every presented output.
  always @(posedge clk) begin
    #1;
    check("onehot", {3'b0, $onehot(oData)}, 4'b0001);
    if (oValid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {3'b0, oValid}, 4'b0000);
      end else begin
        check("result", {1'b0, oData}, {1'b0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc;
    logic         rv;
    int           wait_cnt;

    rst     = 1'b1;
    iData_a = '0;
    iData_b = '0;
    iData   = 3'b000;
    iValid  = 1'b1;
    last_exp = 3'b010;
    #1;
    check("reset_data", {1'b0, oData}, 4'b0010);
    check("reset_valid", {3'b0, oValid}, 4'b0000);
    // Inputs valid during reset must be ignored across edges.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_data", {1'b0, oData}, 4'b0010);
    check("reset_hold_valid", {3'b0, oValid}, 4'b0000);
    @(negedge clk);
    iValid = 1'b0;
    rst    = 1'b0;

    // Directed cases.
    drive(4'b1010, 4'b1101, 3'b001, 1'b1);
    drive(4'b1010, 4'b1001, 3'b001, 1'b1);
    drive(4'b1010, 4'b1010, 3'b010, 1'b1);
    drive(4'b1010, 4'b1010, 3'b100, 1'b1);
    drive(4'b1010, 4'b1010, 3'b001, 1'b1);
    drive(4'b0110, 4'b0110, 3'b000, 1'b1);
    drive(4'b0110, 4'b0110, 3'b011, 1'b1);
    drive(4'b0110, 4'b0110, 3'b111, 1'b1);
    drive(4'b0110, 4'b0110, 3'b101, 1'b1);
    drive(4'b0110, 4'b0110, 3'b110, 1'b1);
    drive(4'b1010, 4'b0011, 3'b010, 1'b1);
    drive(4'b0011, 4'b1010, 3'b010, 1'b1);

    // Idle: output held, valid low.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b1111, 3'b100, 1'b0);
      @(posedge clk);
      #2;
      check("idle_valid", {3'b0, oValid}, 4'b0000);
      check("idle_hold", {1'b0, oData}, {1'b0, last_exp});
    end

    // Asynchronous reset between edges, discarding an in-flight result.
    drive(4'b1111, 4'b0000, 3'b010, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_data", {1'b0, oData}, 4'b0010);
    check("async_rst_valid", {3'b0, oValid}, 4'b0000);
    void'(sb_q.pop_back());
    last_exp = 3'b010;
    iValid = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    check("post_rst_valid", {3'b0, oValid}, 4'b0000);
    check("post_rst_data", {1'b0, oData}, 4'b0010);

    // Randomized traffic, with ties forced often to exercise the cascade.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : W'($urandom);
      rc = 3'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rc, rv);
    end
    drive(4'b0000, 4'b0000, 3'b010, 1'b0);

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    check("drained", 4'(sb_q.size()), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_compare4.md
DATA_COMPARE4 -- requirements
Module: data_compare4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port iData_a  input  WIDTH  operand A.
REQ-005 The block SHALL have port iData_b  input  WIDTH  operand B.
REQ-006 The block SHALL have port iData  input  3  cascade input from the less-significant stage, encoded {GT, EQ, LT}.
REQ-007 The block SHALL have port iValid  input  1  the operands and cascade input are valid this cycle.
REQ-008 The block SHALL have port oData  output  3  registered comparison result, encoded {GT, EQ, LT}.
REQ-009 The block SHALL have port oValid  output  1  oData was updated by the previous valid cycle.
REQ-010 The design SHALL use one clock and an asynchronous active-high reset.

Function
REQ-011 Result encoding SHALL be one-hot: bit2 is A>B (100), bit1 is A==B (010), bit0 is A<B (001).
REQ-012 Comparison of iData_a against iData_b SHALL be unsigned by default, across all WIDTH bits.
REQ-013 A>B SHALL yield 100 regardless of iData.
REQ-014 A<B SHALL yield 001 regardless of iData.
REQ-015 A==B SHALL yield the normalized cascade input, so that lower-order stages decide ties.
REQ-016 Normalization SHALL apply this priority:
- iData[2] set -> 100;
- else iData[0] set -> 001;
- else (010 or 000) -> 010.
REQ-017 Non-one-hot cascade codes (000, 011, 101, 110, 111) SHALL therefore always map to a legal one-hot output.
REQ-018 On a rising clk with iValid=1, oData SHALL load the result, giving a latency of exactly 1 cycle.
REQ-019 On a rising clk with iValid=1, oValid SHALL go to 1 on the same edge.
REQ-020 With iValid=0, oData SHALL hold its previous value and oValid SHALL be 0 on the next edge.
REQ-021 Back-to-back valid cycles SHALL each produce one result with no bubbles and no stalls; there is no backpressure.
REQ-022 oData SHALL always be one-hot, including out of reset.

Reset
REQ-023 Asserting rst SHALL immediately, without waiting for clk, set oData=010 and oValid=0.
REQ-024 While rst is high, oData and oValid SHALL hold their reset values and iValid SHALL be ignored.
REQ-025 A valid input sampled on the edge where rst deasserts SHALL be ignored, and capture SHALL resume on the next edge.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-027 Macro DATA_COMPARE4_SIGNED_EN SHALL select the comparison mode at compile time.
- When defined, iData_a and iData_b SHALL be compared as two's-complement signed values.
- When undefined, they SHALL be compared as unsigned values.
- All other behaviour SHALL be identical in both modes.

Structure
REQ-028 A shared package data_compare4_pkg SHALL hold the cmp_t 3-bit typedef and the constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
REQ-029 The combinational compare-plus-cascade logic SHALL be one sub-module, data_compare4_core, parameterized by WIDTH.
REQ-030 The top level SHALL contain only the core instance and the output/valid registers.

Verification
REQ-031 A bench SHALL cover the following scenarios (WIDTH=4, iValid=1, result checked one edge later):
- a=1010, b=1101, iData=001 -> oData=001; then b=1001 -> oData=100.
- a=1010, b=1010, iData=010 -> oData=010; then iData=100 -> oData=100; then iData=001 -> oData=001.
- a=b=0110 with iData 000, 011, 111 -> oData 010, 001, 100 respectively.
- a=1010, b=0011 -> oData=100 unsigned; -> oData=001 with DATA_COMPARE4_SIGNED_EN (-6<3).
- rst pulsed asynchronously between edges -> oData=010 and oValid=0 immediately, not waiting for clk.
- iValid=0 for 3 cycles -> oData held and oValid=0.
